// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: buffers host writes and hands bytes to
// the transmitter with a tx_start/tx_busy handshake. Optional overflow flag: UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              tx_start,
  output logic [7:0]        tx_data_in,
  input  logic              tx_busy
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic              overflow,
  input  logic              ovf_clr
`endif
);

  localparam int unsigned CW = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [CW-1:0]       count_next;
  logic                wr_accept;
  logic                pop;
  logic                tx_start_next;
  logic [7:0]          tx_data_next;

  // A write while full is dropped even if a pop happens in the same cycle.
  assign wr_accept  = wr_en && !full;
  assign count_next = count + CW'(wr_accept) - CW'(pop);

  // Storage array; no reset needed since only counted entries are ever read.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      state      <= IDLE;
      tx_start   <= 1'b0;
      tx_data_in <= 8'h00;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count      <= count_next;
      full       <= (count_next == CW'(DEPTH));
      empty      <= (count_next == '0);
      state      <= state_next;
      tx_start   <= tx_start_next;
      tx_data_in <= tx_data_next;
    end
  end

  // Handshake: present byte, pop only once the transmitter shows busy.
  always_comb begin
    state_next    = state;
    tx_start_next = tx_start;
    tx_data_next  = tx_data_in;
    pop           = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          tx_data_next  = mem[rd_ptr];
          tx_start_next = 1'b1;
          state_next    = REQ;
        end
      end
      REQ: begin
        if (tx_busy) begin
          tx_start_next = 1'b0;
          pop           = 1'b1;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end
      end
      default: begin
        tx_start_next = 1'b0;
        state_next    = IDLE;
      end
    endcase
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a table of per-cycle vectors plus
// hand-written sequences for fill/drop, write+pop, and async reset.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       tx_start;
  logic [7:0] tx_data_in;
  logic       tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
  logic       overflow;
  logic       ovf_clr;
`endif

  int checks = 0;
  int passed = 0;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .tx_start   (tx_start),
    .tx_data_in (tx_data_in),
    .tx_busy    (tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic       ts;
    logic [7:0] td;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: accepts each tx_start by raising busy for a few cycles.
  task automatic run_tx(input logic [7:0] exp_q[$], input int n);
    int got = 0;
    int cnt = tx_busy ? 2 : 0;
    int cyc = 0;
    while (got < n && cyc < 2000) begin
      if (tx_start && !tx_busy) begin
        chk($sformatf("tx_byte%0d", got), {24'h0, tx_data_in}, {24'h0, exp_q[got]});
        got++;
        tx_busy = 1'b1;
        cnt = 3;
      end else if (tx_busy) begin
        if (cnt == 0) tx_busy = 1'b0;
        else cnt--;
      end
      step();
      cyc++;
    end
    chk("tx_count", got, n);
    tx_busy = 1'b0;
    repeat (3) step();
    chk("drain_tx_start", {31'h0, tx_start}, 32'h0);
    chk("drain_empty", {31'h0, empty}, 32'h1);
  endtask

  initial begin
    logic [7:0] q[$];
    int seen;

    vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0};

    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 1'b0;
`endif
    repeat (2) step();
    chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data_in}, 32'h0);
    chk("rst_count", {27'h0, count}, 32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_full", {31'h0, full}, 32'h0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
`endif
    rst_n = 1'b1;
    step();

    // Single byte latency and a transmitter that acknowledges 5 cycles late.
    for (int i = 0; i < 15; i++) begin
      wr_en = vt[i].wr; wr_data = vt[i].d; tx_busy = vt[i].busy;
      step();
      chk($sformatf("v%0d_tx_start", i), {31'h0, tx_start}, {31'h0, vt[i].ts});
      chk($sformatf("v%0d_tx_data", i), {24'h0, tx_data_in}, {24'h0, vt[i].td});
      chk($sformatf("v%0d_count", i), {27'h0, count}, {27'h0, vt[i].cnt});
      chk($sformatf("v%0d_empty", i), {31'h0, empty}, {31'h0, vt[i].emp});
      chk($sformatf("v%0d_full", i), {31'h0, full}, {31'h0, vt[i].ful});
    end
    wr_en = 1'b0;

    // Fill to full with the transmitter stuck busy, then drop one write.
    tx_busy = 1'b1;
    q = {};
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); q.push_back(8'(i));
      step();
    end
    chk("fill_count", {27'h0, count}, 32'd16);
    chk("fill_full", {31'h0, full}, 32'h1);
    chk("fill_tx_start", {31'h0, tx_start}, 32'h0);
    wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("drop_count", {27'h0, count}, 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf_set", {31'h0, overflow}, 32'h1);
    step();
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);
    wr_en = 1'b1; ovf_clr = 1'b1;
    step();
    wr_en = 1'b0;
    chk("ovf_set_wins", {31'h0, overflow}, 32'h1);
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", {31'h0, overflow}, 32'h0);
`endif
    run_tx(q, 16);
    chk("after_fill_count", {27'h0, count}, 32'd0);

    // Write and pop in the same cycle at count 3.
    tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
      step();
    end
    wr_en = 1'b0; tx_busy = 1'b0;
    step();
    chk("wp_start", {31'h0, tx_start}, 32'h1);
    chk("wp_pre_count", {27'h0, count}, 32'd3);
    tx_busy = 1'b1; wr_en = 1'b1; wr_data = 8'h23;
    step();
    wr_en = 1'b0;
    chk("wp_count", {27'h0, count}, 32'd3);
    q = {8'h21, 8'h22, 8'h23};
    run_tx(q, 3);

    // Asynchronous reset while a request is pending with 4 bytes stored.
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
      step();
    end
    wr_en = 1'b0; tx_busy = 1'b0;
    step();
    chk("ar_pre_start", {31'h0, tx_start}, 32'h1);
    chk("ar_pre_count", {27'h0, count}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_tx_start", {31'h0, tx_start}, 32'h0);
    chk("ar_count", {27'h0, count}, 32'd0);
    chk("ar_empty", {31'h0, empty}, 32'h1);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_start) seen++;
    end
    chk("ar_no_tx", seen, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
